// File: rtl/spi_master_mc.sv
// spi_master_mc: processor-side SPI master for coprocessor slaves.
// A request/response handshake hands one DATA_W frame to a slave, selected
// by req_ss, in any CPOL/CPHA mode. The frame goes out MSB-first on mosi.
// The frame received from miso returns on rsp_data. An out-of-range select
// returns an error response without touching the bus.
// Optional build macro SPI_LOOPBACK_EN adds a loopback input. When it is
// high at accept, mosi feeds the receiver and every select stays high.
//
// Handshakes: a request is taken on a rising clock edge where both req_valid
// and req_ready are high. req_ready is high only in IDLE. rsp_valid is a
// one-cycle pulse that carries rsp_data/rsp_err. There is no back-pressure
// on the response side.
module spi_master_mc #(
  parameter int DATA_W = 32,
  parameter int NUM_SS = 3,
  parameter int DIV    = 2,
  localparam int SS_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clock,
  input  logic              reset,
`ifdef SPI_LOOPBACK_EN
  input  logic              loopback,
`endif
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [SS_W-1:0]   req_ss,
  input  logic [1:0]        req_mode,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [NUM_SS-1:0] nss,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  localparam int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HALF_W = $clog2(2 * DATA_W);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_W - 1);
  localparam logic [SS_W:0]     SS_LIMIT  = (SS_W + 1)'(NUM_SS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_DONE,
    S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;       // cycle count within one DIV period
  logic [HALF_W-1:0]   half_q, half_d;     // sclk half-period index in SHIFT
  logic [1:0]          mode_q, mode_d;     // {CPOL, CPHA} of current transfer
  logic                lb_q, lb_d;         // current transfer is a loopback
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [NUM_SS-1:0]   nss_q, nss_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                ready_q, ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

  logic lb_in;
  logic sample_bit;
  logic leading;

`ifdef SPI_LOOPBACK_EN
  assign lb_in = loopback;
`else
  assign lb_in = 1'b0;
`endif

  // Receiver source: the master's own mosi in loopback, else the bus.
  assign sample_bit = lb_q ? mosi_q : miso;
  // The edge that ends an even half-period leaves the CPOL level.
  assign leading    = ~half_q[0];

  // Next-state and registered-output logic for the transfer sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    half_d      = half_q;
    mode_d      = mode_q;
    lb_d        = lb_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    nss_d       = nss_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          mode_d = req_mode;
          lb_d   = lb_in;
          tx_d   = req_data;
          rx_d   = '0;
          cnt_d  = '0;
          half_d = '0;
          if ({1'b0, req_ss} >= SS_LIMIT) begin
            state_d = S_ERR;
          end else begin
            state_d = S_SETUP;
            sclk_d  = req_mode[1];
            mosi_d  = req_data[DATA_W-1];
            for (int i = 0; i < NUM_SS; i++) begin
              nss_d[i] = lb_in | (req_ss != SS_W'(i));
            end
          end
        end
      end

      S_ERR: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        rsp_data_d  = '0;
        state_d     = S_IDLE;
      end

      S_SETUP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          // CPHA=0 samples on leading edges; CPHA=1 samples on trailing edges.
          if ((!mode_q[0] && leading) || (mode_q[0] && !leading)) begin
            rx_d = {rx_q[DATA_W-2:0], sample_bit};
          end
          // CPHA=1 keeps the MSB from SETUP over the first leading edge.
          if ((!mode_q[0] && !leading) ||
              (mode_q[0] && leading && (half_q != '0))) begin
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
            mosi_d = tx_q[DATA_W-2];
          end
          if (half_q == HALF_LAST) begin
            state_d = S_HOLD;
          end else begin
            half_d = half_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_HOLD: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
          nss_d   = '1;
          mosi_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_data_d  = rx_q;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      half_q      <= '0;
      mode_q      <= 2'b00;
      lb_q        <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      nss_q       <= '1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      half_q      <= half_d;
      mode_q      <= mode_d;
      lb_q        <= lb_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      nss_q       <= nss_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign nss       = nss_q;
  assign sclk      = sclk_q;
  assign mosi      = mosi_q;

endmodule
